// File: rtl/hdmi_text_axi_pkg.sv
// Shared types and constants for the HDMI text controller AXI4-Lite register access path.
//   RESP_OKAY / RESP_SLVERR : AXI read response codes
//   rd_state_t              : read responder FSM states (WAIT only reachable with HDMI_RD_PIPE_EN)
//   idx_width()             : word-index width for a given byte-address width
package hdmi_text_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    CAPTURE,
    RESP
  } rd_state_t;

  // Byte address -> 32-bit word index drops the two byte-lane bits.
  function automatic int unsigned idx_width(input int unsigned addr_width);
    return addr_width - 2;
  endfunction

  localparam int unsigned AXI_ADDR_WIDTH = 12;
  localparam int unsigned IDX_WIDTH      = idx_width(AXI_ADDR_WIDTH);

endpackage

// File: rtl/axi_lite_reg_reader.sv
// AXI4-Lite read-channel responder for the HDMI text controller register bank.
// Accepts one AR request at a time, strobes a synchronous read of the addressed word and
// returns it on R (OKAY), or returns zero with SLVERR for indices beyond NUM_REGS.
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   s_araddr/arvalid/arready : AXI AR channel (byte address, low two bits ignored)
//   s_rdata/rresp/rvalid/rready : AXI R channel
//   reg_rd_en / reg_rd_idx : one-cycle read strobe and word index to the bank
//   reg_rd_data           : bank output, one cycle after the strobe (two with HDMI_RD_PIPE_EN)
//   rd_busy               : high whenever the responder is not idle
//
// Build option: define HDMI_RD_PIPE_EN for banks with a registered output; this adds a WAIT
// state between FETCH and CAPTURE.
module axi_lite_reg_reader
  import hdmi_text_axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NUM_REGS   = 601
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  reg_rd_en,
  output logic [ADDR_WIDTH-3:0] reg_rd_idx,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  rd_busy
);

  localparam int unsigned IdxW = idx_width(ADDR_WIDTH);

  rd_state_t             state_q, state_d;
  logic                  arready_q, arready_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rd_en_q, rd_en_d;
  logic [IdxW-1:0]       rd_idx_q, rd_idx_d;
  logic                  range_ok_q, range_ok_d;
  logic                  busy_q, busy_d;

  logic [IdxW-1:0] ar_idx;
  logic            ar_in_range;
  logic            unused_addr_lsb;

  assign ar_idx          = s_araddr[ADDR_WIDTH-1:2];
  assign unused_addr_lsb = ^s_araddr[1:0];
  // Single range compare at acceptance; the result gates the bank strobe and picks the response.
  assign ar_in_range     = (32'(ar_idx) < NUM_REGS);

  always_comb begin
    state_d    = state_q;
    arready_d  = arready_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rvalid_d   = rvalid_q;
    rd_en_d    = 1'b0;
    rd_idx_d   = rd_idx_q;
    range_ok_d = range_ok_q;

    unique case (state_q)
      IDLE: begin
        if (s_arvalid && arready_q) begin
          rd_idx_d   = ar_idx;
          range_ok_d = ar_in_range;
          rd_en_d    = ar_in_range;
          arready_d  = 1'b0;
          state_d    = FETCH;
        end else begin
          // Covers the first cycle out of reset, where arready is still low.
          arready_d = 1'b1;
        end
      end
      FETCH: begin
`ifdef HDMI_RD_PIPE_EN
        state_d = WAIT;
`else
        state_d = CAPTURE;
`endif
      end
`ifdef HDMI_RD_PIPE_EN
      WAIT: begin
        state_d = CAPTURE;
      end
`endif
      CAPTURE: begin
        if (range_ok_q) begin
          rdata_d = reg_rd_data;
          rresp_d = RESP_OKAY;
        end else begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end
        rvalid_d = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (rvalid_q && s_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      arready_q  <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_idx_q   <= '0;
      range_ok_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      arready_q  <= arready_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rvalid_q   <= rvalid_d;
      rd_en_q    <= rd_en_d;
      rd_idx_q   <= rd_idx_d;
      range_ok_q <= range_ok_d;
      busy_q     <= busy_d;
    end
  end

  assign s_arready  = arready_q;
  assign s_rdata    = rdata_q;
  assign s_rresp    = rresp_q;
  assign s_rvalid   = rvalid_q;
  assign reg_rd_en  = rd_en_q;
  assign reg_rd_idx = rd_idx_q;
  assign rd_busy    = busy_q;

endmodule

// File: tb/tb_axi_lite_reg_reader.sv
// Self-checking bench for axi_lite_reg_reader: directed scenarios plus randomized reads,
// checked against a word-addressed reference of the register bank contents.
module tb_axi_lite_reg_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned NR = 601;
`ifdef HDMI_RD_PIPE_EN
  localparam int ExpLat = 4;  // edges from AR handshake (inclusive) to rvalid visible
`else
  localparam int ExpLat = 3;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] s_araddr = '0;
  logic          s_arvalid = 1'b0;
  logic          s_arready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rvalid;
  logic          s_rready = 1'b1;
  logic          reg_rd_en;
  logic [AW-3:0] reg_rd_idx;
  logic [DW-1:0] reg_rd_data;
  logic          rd_busy;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_lite_reg_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_REGS  (NR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_araddr   (s_araddr),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_rdata    (s_rdata),
    .s_rresp    (s_rresp),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .reg_rd_en  (reg_rd_en),
    .reg_rd_idx (reg_rd_idx),
    .reg_rd_data(reg_rd_data),
    .rd_busy    (rd_busy)
  );

  // Register bank model: synchronous read, optional output register.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] bank_s1 = '0;
  logic [DW-1:0] bank_s2 = '0;
  always @(posedge clk) begin
    if (reg_rd_en) bank_s1 <= mem[reg_rd_idx];
    bank_s2 <= bank_s1;
  end
`ifdef HDMI_RD_PIPE_EN
  assign reg_rd_data = bank_s2;
`else
  assign reg_rd_data = bank_s1;
`endif

  // Strobe monitor.
  int            en_cnt = 0;
  logic [AW-3:0] en_idx = '0;
  always @(negedge clk) begin
    if (reg_rd_en === 1'b1) begin
      en_cnt <= en_cnt + 1;
      en_idx <= reg_rd_idx;
    end
  end

  // Reference: word = byte address / 4; words past the implemented range read as SLVERR/zero.
  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    int unsigned idx = int'(a) / 4;
    return (idx < NR) ? mem[idx] : '0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [AW-1:0] a);
    int unsigned idx = int'(a) / 4;
    return (idx < NR) ? 2'b00 : 2'b10;
  endfunction

  // One read transaction; hold = cycles of rready low after rvalid rises.
  task automatic do_read(input logic [AW-1:0] a, input int hold,
                         output logic [DW-1:0] d, output logic [1:0] r, output int lat,
                         output int pulses, output logic [AW-3:0] pidx, output bit stable,
                         output bit done);
    int n;
    int c0;
    done = 0; stable = 1; lat = 0; pulses = 0; pidx = '0; d = '0; r = '0;
    s_rready  = (hold == 0);
    s_araddr  = a;
    s_arvalid = 1'b1;
    n = 0;
    while (s_arready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (s_arready !== 1'b1) begin
      s_arvalid = 1'b0;
      return;
    end
    c0 = en_cnt;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    lat = 1;
    while (s_rvalid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (s_rvalid !== 1'b1) return;
    d = s_rdata;
    r = s_rresp;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (s_rvalid !== 1'b1 || s_rdata !== d || s_rresp !== r || s_arready !== 1'b0) stable = 0;
    end
    s_rready = 1'b1;
    @(posedge clk); #1;
    pulses = en_cnt - c0;
    pidx   = en_idx;
    done   = (s_rvalid === 1'b0 && s_arready === 1'b1 && rd_busy === 1'b0);
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({s_arready, s_rvalid, reg_rd_en, rd_busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: arready/rvalid/rd_en/busy = %b, required 0000",
               {s_arready, s_rvalid, reg_rd_en, rd_busy});
    end
    n_checks++;
    if (s_rdata !== '0 || s_rresp !== 2'b00 || reg_rd_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h rresp=%b idx=%0d, required 0/00/0",
               s_rdata, s_rresp, reg_rd_idx);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (s_arready !== 1'b0) begin
      n_fail++;
      $display("FAIL arready_pre_edge: got %b, required 0", s_arready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (s_arready !== 1'b1) begin
      n_fail++;
      $display("FAIL arready_first_edge: got %b, required 1", s_arready);
    end
    // Mid-simulation reset acts without a clock edge.
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (s_arready !== 1'b0 || rd_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: arready=%b busy=%b, required 0/0", s_arready, rd_busy);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (s_arready !== 1'b1) begin
      n_fail++;
      $display("FAIL arready_after_rerelease: got %b, required 1", s_arready);
    end
  endtask

  task automatic test_in_range(input logic [AW-1:0] a, input string tag);
    logic [DW-1:0] d; logic [1:0] r; int lat, pulses; logic [AW-3:0] pidx; bit st, done;
    do_read(a, 0, d, r, lat, pulses, pidx, st, done);
    n_checks++;
    if (d !== exp_data(a) || r !== exp_resp(a)) begin
      n_fail++;
      $display("FAIL %s_data: rdata=%h rresp=%b, required %h/%b", tag, d, r,
               exp_data(a), exp_resp(a));
    end
    n_checks++;
    if (lat !== ExpLat) begin
      n_fail++;
      $display("FAIL %s_latency: %0d edges, required %0d", tag, lat, ExpLat);
    end
    n_checks++;
    if (pulses !== 1 || pidx !== a[AW-1:2]) begin
      n_fail++;
      $display("FAIL %s_strobe: %0d pulses idx %0d, required 1 pulse idx %0d", tag, pulses,
               pidx, a[AW-1:2]);
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_return_idle: done=%0d, required 1", tag, done);
    end
  endtask

  task automatic test_out_of_range;
    logic [DW-1:0] d; logic [1:0] r; int lat, pulses; logic [AW-3:0] pidx; bit st, done;
    do_read(12'h964, 0, d, r, lat, pulses, pidx, st, done);
    n_checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      n_fail++;
      $display("FAIL oor_resp: rdata=%h rresp=%b, required 0/10", d, r);
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL oor_strobe: %0d pulses, required 0", pulses);
    end
    n_checks++;
    if (!done || lat !== ExpLat) begin
      n_fail++;
      $display("FAIL oor_timing: done=%0d lat=%0d, required 1/%0d", done, lat, ExpLat);
    end
  endtask

  task automatic test_backpressure;
    logic [AW-1:0] a1, a2; logic [DW-1:0] d; logic [1:0] r; int n, c0;
    a1 = 12'h040;
    a2 = 12'h088;
    s_rready  = 1'b0;
    s_araddr  = a1;
    s_arvalid = 1'b1;
    n = 0;
    while (s_arready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    s_araddr = a2;  // second request held through the busy window
    n = 0;
    while (s_rvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (s_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_rvalid_timeout: rvalid=%b, required 1", s_rvalid);
    end
    d  = s_rdata;
    r  = s_rresp;
    c0 = en_cnt;
    n_checks++;
    if (d !== exp_data(a1) || r !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_first_data: %h/%b, required %h/00", d, r, exp_data(a1));
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (s_rvalid !== 1'b1 || s_rdata !== d || s_rresp !== r || s_arready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: rvalid=%b rdata=%h rresp=%b arready=%b, required 1/%h/%b/0",
                 i, s_rvalid, s_rdata, s_rresp, s_arready, d, r);
      end
    end
    n_checks++;
    if (en_cnt !== c0) begin
      n_fail++;
      $display("FAIL bp_no_accept: %0d strobes during hold, required 0", en_cnt - c0);
    end
    s_rready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: rvalid=%b arready=%b, required 0/1", s_rvalid, s_arready);
    end
    @(posedge clk); #1;  // pending second request is accepted here
    s_arvalid = 1'b0;
    n = 0;
    while (s_rvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== exp_data(a2) || s_rresp !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_second: rvalid=%b rdata=%h rresp=%b, required 1/%h/00",
               s_rvalid, s_rdata, s_rresp, exp_data(a2));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] d; logic [1:0] r; int lat, pulses, n; logic [AW-3:0] pidx; bit st, done;
    mem[0] = $urandom;
    mem[9] = $urandom;
    s_rready  = 1'b0;
    s_araddr  = 12'h024;
    s_arvalid = 1'b1;
    n = 0;
    while (s_arready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    n = 0;
    while (s_rvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (s_rvalid !== 1'b0 || s_rdata !== '0 || rd_busy !== 1'b0 || s_arready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: rvalid=%b rdata=%h busy=%b arready=%b, required 0/0/0/0",
               s_rvalid, s_rdata, rd_busy, s_arready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (s_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_stale_beat: rvalid=%b, required 0", s_rvalid);
    end
    do_read(12'h000, 0, d, r, lat, pulses, pidx, st, done);
    n_checks++;
    if (d !== mem[0] || r !== 2'b00 || !done) begin
      n_fail++;
      $display("FAIL midreset_next_read: %h/%b done=%0d, required %h/00 done=1", d, r, done,
               mem[0]);
    end
  endtask

  task automatic test_random;
    logic [AW-1:0] a; logic [DW-1:0] d; logic [1:0] r; int lat, pulses, hold;
    logic [AW-3:0] pidx; bit st, done; int unsigned idx;
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, NR - 1);
        a   = AW'(idx * 4 + $urandom_range(0, 3));
      end else begin
        a = AW'($urandom_range(0, 4095));
      end
      hold = $urandom_range(0, 2);
      do_read(a, hold, d, r, lat, pulses, pidx, st, done);
      n_checks++;
      if (d !== exp_data(a) || r !== exp_resp(a) || lat !== ExpLat || !st || !done) begin
        n_fail++;
        $display("FAIL rand_%0d addr %h: rdata=%h rresp=%b lat=%0d stable=%0d done=%0d, required %h/%b/%0d/1/1",
                 k, a, d, r, lat, st, done, exp_data(a), exp_resp(a), ExpLat);
      end
      n_checks++;
      if (pulses !== ((exp_resp(a) == 2'b00) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL rand_strobe_%0d addr %h: %0d pulses, required %0d", k, a, pulses,
                 (exp_resp(a) == 2'b00) ? 1 : 0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[5] = 32'hDEADBEEF;
    test_reset();
    test_in_range(12'h014, "inrange");
    test_in_range(12'h017, "unaligned");
    test_in_range(12'h960, "last_word");
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
